// File: rtl/apb_req_master.sv
// apb_req_master: turns a valid/ready request into one APB transfer and
// returns the result on a valid/ready response channel.
//
// Handshake semantics (request and response channels alike): a transfer
// happens on a rising clk edge where valid and ready are both high; the
// source holds valid and its payload stable until that edge, and ready
// never depends combinationally on valid.
//
// The debug output dbg_state_o carries the FSM state encoding
// (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP).
module apb_req_master #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 16,
    localparam int STRB_W    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [BUS_WIDTH-1:0]  req_wdata_i,
    input  logic [STRB_W-1:0]     req_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [STRB_W-1:0]     pstrb_o,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The wait counter is compared against TIMEOUT-1: the ACCESS cycle that
    // finds the counter there is the TIMEOUT-th one and ends the transfer.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            wait_q, wait_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = req_write_i;
                    paddr_d   = req_addr_i;
                    // Reads never drive data or strobes onto the bus.
                    pwdata_d  = req_write_i ? req_wdata_i : '0;
                    pstrb_d   = req_write_i ? req_strb_i : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Testbench for apb_req_master (TIMEOUT=4) with a small APB slave model.
module tb_apb_req_master;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0, prdata;
  logic [3:0]  req_strb = '0;
  logic        req_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, pwdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [15:0] paddr;
  logic [3:0]  pstrb;
  logic [1:0]  dbg_state;

  // slave model: pready after slave_waits stalled ACCESS cycles
  logic [7:0]  slave_waits = 8'd0, acc_cnt = 8'd0;
  logic        slave_err = 0, slave_noise = 0;
  logic [31:0] slave_rdata = '0;
  always @(posedge clk) acc_cnt <= (psel && penable) ? acc_cnt + 8'd1 : 8'd0;
  assign pready  = (psel && penable) ? (acc_cnt == slave_waits) : slave_noise;
  assign pslverr = slave_err;
  assign prdata  = slave_rdata;

  apb_req_master #(.DATA_WIDTH(8), .BUS_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];   // {timeout, err, rdata}
  logic [33:0] exp_v;
  int n_cmp = 0;
  int n_bad = 0;

  // observations from the driver
  int          obs_setup, obs_pen, obs_lat;
  logic        obs_seen, obs_stable, obs_rsp_stable, obs_rdy_low, obs_done, obs_idle;
  logic        obs_pwrite;
  logic [1:0]  obs_psel_rsp;
  logic [15:0] obs_paddr;
  logic [31:0] obs_pwdata;
  logic [3:0]  obs_pstrb;
  logic [33:0] obs_rsp;

  // ---------------- driver ----------------
  // Starts from an IDLE sample point (#1 after an edge) and runs one transfer.
  task automatic run_xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int waits, input logic err,
                          input logic [31:0] rd, input int hold);
    slave_waits = waits[7:0]; slave_err = err; slave_rdata = rd;
    req_write = w; req_addr = a; req_wdata = d; req_strb = s; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    obs_pwrite = pwrite; obs_paddr = paddr; obs_pwdata = pwdata; obs_pstrb = pstrb;
    obs_setup = 0; obs_pen = 0; obs_lat = 0; obs_stable = 1;
    while (!rsp_valid && obs_lat < 50) begin
      if (psel && !penable) obs_setup++;
      if (psel && penable) begin
        obs_pen++;
        if ({pwrite, paddr, pwdata, pstrb} !== {obs_pwrite, obs_paddr, obs_pwdata, obs_pstrb})
          obs_stable = 0;
      end
      @(posedge clk); #1;
      obs_lat++;
    end
    obs_seen = rsp_valid;
    obs_psel_rsp = {psel, penable};
    obs_rsp = {rsp_timeout, rsp_err, rsp_rdata};
    obs_rsp_stable = 1; obs_rdy_low = 1; obs_done = 0; obs_idle = 0;
    if (obs_seen) begin
      for (int i = 0; i < hold; i++) begin
        req_valid = 1; req_addr = a ^ 16'h5555;
        @(posedge clk); #1;
        if ({rsp_valid, rsp_timeout, rsp_err, rsp_rdata} !== {1'b1, obs_rsp}) obs_rsp_stable = 0;
        if (req_ready !== 1'b0 || psel !== 1'b0) obs_rdy_low = 0;
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0; req_valid = 0;
      obs_done = (rsp_valid === 1'b0 && req_ready === 1'b1);
      @(posedge clk); #1;
      obs_idle = (psel === 1'b0 && req_ready === 1'b1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if ({psel, penable, pwrite} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl: got %b want 000", {psel, penable, pwrite}); end
    n_cmp++; if ({paddr, pwdata, pstrb} !== 52'd0) begin n_bad++; $display("FAIL reset_bus: got %h want 0", {paddr, pwdata, pstrb}); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 35'd0) begin n_bad++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}); end
  endtask

  task automatic test_write;
    slave_noise = 1;   // pready high outside ACCESS must be ignored
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    run_xfer(1'b1, 16'h0040, 32'h04030201, 4'hF, 0, 1'b0, 32'hCAFEF00D, 0);
    slave_noise = 0;
    exp_v = exp_q.pop_front();
    n_cmp++; if ({obs_pwrite, obs_paddr, obs_pwdata, obs_pstrb} !== {1'b1, 16'h0040, 32'h04030201, 4'hF}) begin n_bad++; $display("FAIL wr_setup_fields: got %h want %h", {obs_pwrite, obs_paddr, obs_pwdata, obs_pstrb}, {1'b1, 16'h0040, 32'h04030201, 4'hF}); end
    n_cmp++; if (obs_setup !== 1 || obs_pen !== 1) begin n_bad++; $display("FAIL wr_phases: setup %0d access %0d want 1 1", obs_setup, obs_pen); end
    n_cmp++; if (obs_lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d want 2", obs_lat); end
    n_cmp++; if (obs_rsp !== exp_v) begin n_bad++; $display("FAIL wr_rsp: got %h want %h", obs_rsp, exp_v); end
    n_cmp++; if (obs_psel_rsp !== 2'b00) begin n_bad++; $display("FAIL wr_psel_drop: got %b want 00", obs_psel_rsp); end
    n_cmp++; if (obs_done !== 1'b1 || obs_idle !== 1'b1) begin n_bad++; $display("FAIL wr_return_idle: got %b%b want 11", obs_done, obs_idle); end
  endtask

  task automatic test_read_wait;
    exp_q.push_back({1'b0, 1'b0, 32'h0000005A});
    run_xfer(1'b0, 16'h0100, 32'h11223344, 4'hF, 3, 1'b0, 32'h0000005A, 0);
    exp_v = exp_q.pop_front();
    n_cmp++; if ({obs_pwrite, obs_paddr, obs_pwdata, obs_pstrb} !== {1'b0, 16'h0100, 32'h0, 4'h0}) begin n_bad++; $display("FAIL rd_setup_fields: got %h want %h", {obs_pwrite, obs_paddr, obs_pwdata, obs_pstrb}, {1'b0, 16'h0100, 32'h0, 4'h0}); end
    n_cmp++; if (obs_pen !== 4) begin n_bad++; $display("FAIL rd_wait_penable: got %0d want 4", obs_pen); end
    n_cmp++; if (obs_stable !== 1'b1) begin n_bad++; $display("FAIL rd_wait_stable: got %b want 1", obs_stable); end
    n_cmp++; if (obs_rsp !== exp_v) begin n_bad++; $display("FAIL rd_wait_rsp: got %h want %h", obs_rsp, exp_v); end
  endtask

  task automatic test_slverr;
    exp_q.push_back({1'b0, 1'b1, 32'hDEADBEEF});
    run_xfer(1'b0, 16'h0200, 32'h0, 4'h0, 0, 1'b1, 32'hDEADBEEF, 0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (obs_rsp !== exp_v) begin n_bad++; $display("FAIL rd_slverr_rsp: got %h want %h", obs_rsp, exp_v); end
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    run_xfer(1'b1, 16'h0204, 32'hA5A5A5A5, 4'h3, 1, 1'b1, 32'hDEADBEEF, 0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (obs_rsp !== exp_v) begin n_bad++; $display("FAIL wr_slverr_rsp: got %h want %h", obs_rsp, exp_v); end
    n_cmp++; if (obs_pstrb !== 4'h3) begin n_bad++; $display("FAIL wr_slverr_strb: got %h want 3", obs_pstrb); end
  endtask

  task automatic test_timeout;
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    run_xfer(1'b0, 16'h0300, 32'h0, 4'h0, 255, 1'b0, 32'h12345678, 0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (obs_pen !== TO) begin n_bad++; $display("FAIL to_access_cycles: got %0d want %0d", obs_pen, TO); end
    n_cmp++; if (obs_lat !== TO + 1) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", obs_lat, TO + 1); end
    n_cmp++; if (obs_rsp !== exp_v) begin n_bad++; $display("FAIL to_rsp: got %h want %h", obs_rsp, exp_v); end
    n_cmp++; if (obs_psel_rsp !== 2'b00) begin n_bad++; $display("FAIL to_psel_drop: got %b want 00", obs_psel_rsp); end
  endtask

  task automatic test_rsp_hold;
    exp_q.push_back({1'b0, 1'b0, 32'h87654321});
    run_xfer(1'b0, 16'h0400, 32'h0, 4'h0, 0, 1'b0, 32'h87654321, 5);
    exp_v = exp_q.pop_front();
    n_cmp++; if (obs_rsp !== exp_v) begin n_bad++; $display("FAIL hold_rsp: got %h want %h", obs_rsp, exp_v); end
    n_cmp++; if (obs_rsp_stable !== 1'b1) begin n_bad++; $display("FAIL hold_rsp_stable: got %b want 1", obs_rsp_stable); end
    n_cmp++; if (obs_rdy_low !== 1'b1) begin n_bad++; $display("FAIL hold_req_ready_low: got %b want 1", obs_rdy_low); end
    n_cmp++; if (obs_done !== 1'b1 || obs_idle !== 1'b1) begin n_bad++; $display("FAIL hold_req_ignored: got %b%b want 11", obs_done, obs_idle); end
  endtask

  task automatic test_back_to_back;
    logic        w, e;
    logic [15:0] a;
    logic [31:0] d, rd;
    logic [3:0]  s;
    int          wt;
    for (int k = 0; k < 8; k++) begin
      w = 1'($urandom_range(0, 1)); e = 1'($urandom_range(0, 1));
      a = 16'($urandom); d = $urandom; rd = $urandom; s = 4'($urandom_range(0, 15));
      wt = $urandom_range(0, 3);
      exp_q.push_back({1'b0, e, (w ? 32'h0 : rd)});
      run_xfer(w, a, d, s, wt, e, rd, $urandom_range(0, 2));
      exp_v = exp_q.pop_front();
      n_cmp++; if (obs_rsp !== exp_v) begin n_bad++; $display("FAIL b2b_rsp[%0d]: got %h want %h", k, obs_rsp, exp_v); end
      n_cmp++; if ({obs_pwrite, obs_paddr, obs_pwdata, obs_pstrb} !== {w, a, (w ? d : 32'h0), (w ? s : 4'h0)}) begin n_bad++; $display("FAIL b2b_setup[%0d]: got %h want %h", k, {obs_pwrite, obs_paddr, obs_pwdata, obs_pstrb}, {w, a, (w ? d : 32'h0), (w ? s : 4'h0)}); end
      n_cmp++; if (obs_pen !== wt + 1 || obs_lat !== wt + 2) begin n_bad++; $display("FAIL b2b_timing[%0d]: access %0d lat %0d want %0d %0d", k, obs_pen, obs_lat, wt + 1, wt + 2); end
    end
  endtask

  task automatic test_reset_mid;
    logic rv_seen;
    slave_waits = 8'd255;
    req_write = 1; req_addr = 16'h0500; req_wdata = 32'hFFFF0000; req_strb = 4'hC; req_valid = 1;
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); #1;
    n_cmp++; if ({psel, penable} !== 2'b11) begin n_bad++; $display("FAIL rstmid_in_access: got %b want 11", {psel, penable}); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({psel, penable, rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL rstmid_async: got %b want 000", {psel, penable, rsp_valid}); end
    #3 rst_n = 1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_release: ready %b valid %b want 1 0", req_ready, rsp_valid); end
    rv_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || psel !== 1'b0) rv_seen = 1;
    end
    n_cmp++; if (rv_seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_rsp: got %b want 0", rv_seen); end
  endtask

  // ---------------- sequence & report ----------------
  initial begin
    test_reset;
    test_write;
    test_read_wait;
    test_slverr;
    test_timeout;
    test_rsp_hold;
    test_back_to_back;
    test_reset_mid;
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drained: got %0d entries want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_req_master.md
APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 The block SHALL use parameter DATA_WIDTH, default 8, as the byte-lane granule width.
REQ-002 The block SHALL use parameter BUS_WIDTH, default 32, as the APB data width; strobe width is STRB_W = BUS_WIDTH/DATA_WIDTH.
REQ-003 The block SHALL use parameter ADDR_WIDTH, default 16, as the APB address width.
REQ-004 The block SHALL use parameter TIMEOUT, default 16, as the maximum ACCESS cycles waited for pready (legal range 1..255).
REQ-005 The block SHALL have these ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_write_i  in  1  1=write, 0=read.
- req_addr_i  in  ADDR_WIDTH  target address.
- req_wdata_i  in  BUS_WIDTH  write data.
- req_strb_i  in  STRB_W  write byte strobes.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  BUS_WIDTH  read data (0 for writes).
- rsp_err_o  out  1  slave error or timeout.
- rsp_timeout_o  out  1  transfer aborted by timeout.
- psel_o, penable_o, pwrite_o  out  1  APB controls.
- paddr_o  out  ADDR_WIDTH; pwdata_o  out  BUS_WIDTH; pstrb_o  out  STRB_W.
- prdata_i  in  BUS_WIDTH; pready_i  in  1; pslverr_i  in  1  APB slave returns.

Function
REQ-006 The block SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all APB and rsp outputs registered.
REQ-007 req_ready_o SHALL be high iff state is IDLE; a handshake latches write/addr/wdata/strb and moves to SETUP.
REQ-008 In SETUP the block SHALL drive psel_o=1, penable_o=0 with latched pwrite_o/paddr_o/pwdata_o/pstrb_o, for exactly one cycle, then ACCESS.
REQ-009 In ACCESS the block SHALL drive psel_o=1, penable_o=1 with address/data/strobe held stable until the transfer completes.
REQ-010 On an ACCESS cycle with pready_i=1 the block SHALL capture prdata_i (reads only, else 0) and pslverr_i into rsp_rdata_o/rsp_err_o, set rsp_timeout_o=0, deassert psel_o/penable_o, and enter RESP.
REQ-011 A wait counter SHALL clear on SETUP->ACCESS and increment per ACCESS cycle with pready_i=0; on reaching TIMEOUT the block SHALL deassert psel_o/penable_o, set rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0, and enter RESP.
REQ-012 pstrb_o SHALL be driven 0 for reads; pwdata_o SHALL be 0 for reads.
REQ-013 In RESP rsp_valid_o SHALL be 1 and response fields held until rsp_ready_i=1, then rsp_valid_o drops next cycle and state returns to IDLE.
REQ-014 Minimum latency: handshake at edge N -> psel_o at N+1, penable_o at N+2, rsp_valid_o at N+3 when pready_i=1 on first ACCESS cycle; next req_ready_o at N+4 if rsp_ready_i held high.
REQ-015 Outside SETUP/ACCESS psel_o and penable_o SHALL be 0; paddr_o/pwdata_o/pstrb_o/pwrite_o may hold last values.
REQ-016 pready_i, pslverr_i, prdata_i SHALL be ignored outside ACCESS.
REQ-017 req_valid_i while not IDLE SHALL be ignored (no queuing); caller holds it.

Reset
REQ-018 Reset assertion SHALL immediately force state IDLE, psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, pstrb_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0, counter=0; req_ready_o=1 after release.
REQ-019 Reset mid-transfer SHALL abandon it with no response produced.

Verification
REQ-020 Write addr 0x0040 data 0x04030201 strb 0xF, pready=1 immediately -> one SETUP, one ACCESS cycle, pstrb_o=0xF, rsp_valid with err=0, rdata=0.
REQ-021 Read addr 0x0100, slave inserts 3 wait states, prdata=0x0000005A -> penable_o high 4 cycles, rsp_rdata_o=0x5A, err=0.
REQ-022 Read with pready=1, pslverr=1 -> rsp_err_o=1, rsp_timeout_o=0, rdata=0x00000000 ignored only if write; for read, captured prdata.
REQ-023 TIMEOUT=4, pready held 0 -> ACCESS lasts 4 cycles, psel_o drops, rsp_err_o=1, rsp_timeout_o=1.
REQ-024 rsp_ready_i held 0 for 5 cycles -> rsp fields stable, req_ready_o=0 throughout, new req_valid_i ignored.
REQ-025 rst_n_i asserted during ACCESS -> psel_o/penable_o 0 asynchronously, no rsp_valid_o, req_ready_o=1 first cycle after release.
